// File: rtl/bus_slave_regfile_pkg.sv
// Shared bus constants and slave FSM state encodings.
// Peripheral register blocks on the system bus import these.
package bus_slave_regfile_pkg;

  localparam int   WORD_ADDR_W  = 30;
  localparam int   WORD_DATA_W  = 32;

  localparam logic READ         = 1'b1;
  localparam logic WRITE        = 1'b0;
  localparam logic ENABLE_      = 1'b0;
  localparam logic DISABLE_     = 1'b1;
  localparam logic RESET_ENABLE = 1'b0;

  typedef enum logic [1:0] {
    BUS_SLV_IDLE = 2'd0,
    BUS_SLV_WAIT = 2'd1,
    BUS_SLV_ACK  = 2'd2
  } bus_slv_state_e;

endpackage

// File: rtl/bus_slave_regfile_if.sv
// Slave-side view of the shared system bus.
// The master modport drives the request signals; the slave modport answers them.
interface bus_slave_regfile_if;
  import bus_slave_regfile_pkg::*;

  logic                   s_cs_;
  logic                   s_as_;
  logic                   s_rw;
  logic [WORD_ADDR_W-1:0] s_addr;
  logic [WORD_DATA_W-1:0] s_wr_data;
  logic [WORD_DATA_W-1:0] s_rd_data;
  logic                   s_rdy_;

  modport master (
    output s_cs_, s_as_, s_rw, s_addr, s_wr_data,
    input  s_rd_data, s_rdy_
  );

  modport slave (
    input  s_cs_, s_as_, s_rw, s_addr, s_wr_data,
    output s_rd_data, s_rdy_
  );

endinterface

// File: rtl/bus_slave_regfile.sv
// Template bus responder: accepts a request, waits WAIT_CYCLES, then acknowledges
// for one cycle against a small register file whose register 0 is a read-only ID.
module bus_slave_regfile
  import bus_slave_regfile_pkg::*;
#(
  parameter int                     REG_NUM_W   = 4,
  parameter int                     WAIT_CYCLES = 2,
  parameter logic [WORD_DATA_W-1:0] ID_VALUE    = 32'h0000_0001
) (
  input logic                 clk,
  input logic                 reset_,
  bus_slave_regfile_if.slave  bus
);

  localparam int NUM_REGS = 2 ** REG_NUM_W;

  bus_slv_state_e         state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [REG_NUM_W-1:0]   idx_q, idx_d;
  logic                   rw_q, rw_d;
  logic [WORD_DATA_W-1:0] wdata_q, wdata_d;
  logic                   rdy_q, rdy_d;
  logic [WORD_DATA_W-1:0] rdata_q, rdata_d;
  logic                   wr_en;
  logic [WORD_DATA_W-1:0] regs_q [NUM_REGS];
  logic [WORD_DATA_W-1:0] rd_word;

  assign rd_word       = (idx_q == '0) ? ID_VALUE : regs_q[idx_q];
  assign bus.s_rdy_    = rdy_q;
  assign bus.s_rd_data = rdata_q;

  // The acknowledge and read data are registered, so they appear in the cycle after ACK.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    rdy_d   = DISABLE_;
    rdata_d = '0;
    wr_en   = 1'b0;
    unique case (state_q)
      BUS_SLV_IDLE: begin
        if (bus.s_cs_ == ENABLE_ && bus.s_as_ == ENABLE_) begin
          idx_d   = bus.s_addr[REG_NUM_W-1:0];
          rw_d    = bus.s_rw;
          wdata_d = bus.s_wr_data;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? BUS_SLV_WAIT : BUS_SLV_ACK;
        end
      end
      BUS_SLV_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = BUS_SLV_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      BUS_SLV_ACK: begin
        state_d = BUS_SLV_IDLE;
        rdy_d   = ENABLE_;
        if (rw_q == READ) begin
          rdata_d = rd_word;
        end else begin
          wr_en = 1'b1;
        end
      end
      default: state_d = BUS_SLV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= BUS_SLV_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rdy_q   <= DISABLE_;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rdy_q   <= rdy_d;
      rdata_q <= rdata_d;
    end
  end

  // Register 0 is never written, so its storage stays at its reset value.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en && idx_q != '0) begin
      regs_q[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_bus_slave_regfile.sv
// Self-checking bench: two responders (2 and 0 wait states) driven with directed
// and random transfers, compared against an array model of the register file.
module tb_bus_slave_regfile;
  import bus_slave_regfile_pkg::*;

  localparam logic [31:0] ID = 32'h0000_0001;

  logic clk = 1'b0;
  logic reset_;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] model2 [16];
  logic [31:0] model0 [16];

  bus_slave_regfile_if bus2 ();
  bus_slave_regfile_if bus0 ();

  bus_slave_regfile #(.REG_NUM_W(4), .WAIT_CYCLES(2), .ID_VALUE(ID)) u_dut2 (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus2.slave)
  );

  bus_slave_regfile #(.REG_NUM_W(4), .WAIT_CYCLES(0), .ID_VALUE(ID)) u_dut0 (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus0.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setBus(input int sel, input logic cs, input logic as, input logic rw,
                        input logic [29:0] addr, input logic [31:0] data);
    if (sel == 0) begin
      bus0.s_cs_ = cs; bus0.s_as_ = as; bus0.s_rw = rw;
      bus0.s_addr = addr; bus0.s_wr_data = data;
    end else begin
      bus2.s_cs_ = cs; bus2.s_as_ = as; bus2.s_rw = rw;
      bus2.s_addr = addr; bus2.s_wr_data = data;
    end
  endtask

  function automatic logic getRdy(input int sel);
    return (sel == 0) ? bus0.s_rdy_ : bus2.s_rdy_;
  endfunction

  function automatic logic [31:0] getRd(input int sel);
    return (sel == 0) ? bus0.s_rd_data : bus2.s_rd_data;
  endfunction

  function automatic logic [31:0] modelRead(input int sel, input logic [29:0] addr);
    int idx = int'(addr[3:0]);
    if (idx == 0) return ID;
    return (sel == 0) ? model0[idx] : model2[idx];
  endfunction

  task automatic modelWrite(input int sel, input logic [29:0] addr, input logic [31:0] data);
    int idx = int'(addr[3:0]);
    if (idx != 0) begin
      if (sel == 0) model0[idx] = data;
      else          model2[idx] = data;
    end
  endtask

  task automatic clearModels();
    for (int i = 0; i < 16; i++) begin
      model0[i] = '0;
      model2[i] = '0;
    end
  endtask

  // One complete transfer; bus inputs are scrambled right after acceptance.
  task automatic applyStimulus(input int sel, input logic rw, input logic [29:0] addr,
                               input logic [31:0] data, input string tag);
    int          waitStates = (sel == 0) ? 0 : 2;
    int          lat = 0;
    logic [31:0] expRd;
    expRd = (rw == READ) ? modelRead(sel, addr) : 32'h0;
    @(negedge clk);
    setBus(sel, ENABLE_, ENABLE_, rw, addr, data);
    @(posedge clk);
    @(negedge clk);
    setBus(sel, DISABLE_, DISABLE_, ~rw, 30'($urandom), $urandom);
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (getRdy(sel) == ENABLE_) break;
    end
    check({tag, "_latency"}, 32'(lat), 32'(waitStates + 1));
    check({tag, "_rdata"}, getRd(sel), expRd);
    if (rw == WRITE) modelWrite(sel, addr, data);
    @(posedge clk); #1;
    check({tag, "_rdy_pulse"}, 32'(getRdy(sel)), 32'(DISABLE_));
    check({tag, "_rdata_idle"}, getRd(sel), 32'h0);
  endtask

  initial begin
    setBus(0, DISABLE_, DISABLE_, READ, '0, '0);
    setBus(2, DISABLE_, DISABLE_, READ, '0, '0);
    clearModels();

    reset_ = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdy2", 32'(bus2.s_rdy_), 32'h1);
    check("reset_rd2", bus2.s_rd_data, 32'h0);
    check("reset_rdy0", 32'(bus0.s_rdy_), 32'h1);
    check("reset_rd0", bus0.s_rd_data, 32'h0);
    @(negedge clk);
    reset_ = 1'b1;

    applyStimulus(2, READ, 30'h5, 32'h0, "rd5_after_reset");
    applyStimulus(2, WRITE, 30'h3, 32'hDEAD_BEEF, "wr3");
    applyStimulus(2, READ, 30'h3, 32'h0, "rd3");
    applyStimulus(2, WRITE, 30'h0, 32'hFFFF_FFFF, "wr0");
    applyStimulus(2, READ, 30'h0, 32'h0, "rd0_id");
    applyStimulus(2, READ, 30'h3FFF_FFF3, 32'h0, "rd3_upper_bits");

    // Back-to-back writes with the strobe held low on the zero-wait responder.
    @(negedge clk);
    setBus(0, ENABLE_, ENABLE_, WRITE, 30'h1, 32'h1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("b2b_rdy_%0d", k), 32'(bus0.s_rdy_), (k % 2 == 1) ? 32'h0 : 32'h1);
      @(negedge clk);
      if (k == 0) setBus(0, ENABLE_, ENABLE_, WRITE, 30'h2, 32'h2);
      if (k == 2) setBus(0, ENABLE_, ENABLE_, WRITE, 30'h3, 32'h3);
      if (k == 4) setBus(0, DISABLE_, DISABLE_, READ, '0, '0);
    end
    modelWrite(0, 30'h1, 32'h1);
    modelWrite(0, 30'h2, 32'h2);
    modelWrite(0, 30'h3, 32'h3);
    applyStimulus(0, READ, 30'h1, 32'h0, "b2b_rd1");
    applyStimulus(0, READ, 30'h2, 32'h0, "b2b_rd2");
    applyStimulus(0, READ, 30'h3, 32'h0, "b2b_rd3");

    // Strobe without chip select must never be acknowledged.
    @(negedge clk);
    setBus(2, DISABLE_, ENABLE_, WRITE, 30'h3, 32'hBAD0_BAD0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("nocs_rdy_%0d", k), 32'(bus2.s_rdy_), 32'h1);
    end
    @(negedge clk);
    setBus(2, DISABLE_, DISABLE_, READ, '0, '0);
    applyStimulus(2, READ, 30'h3, 32'h0, "nocs_rd3");

    // Reset during WAIT loses the pending write and issues no acknowledge.
    @(negedge clk);
    setBus(2, ENABLE_, ENABLE_, WRITE, 30'h7, 32'h1234_5678);
    @(posedge clk);
    @(negedge clk);
    reset_ = 1'b0;
    setBus(2, DISABLE_, DISABLE_, READ, '0, '0);
    clearModels();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("rst_wait_rdy_%0d", k), 32'(bus2.s_rdy_), 32'h1);
      @(negedge clk);
      if (k == 1) reset_ = 1'b1;
    end
    applyStimulus(2, READ, 30'h7, 32'h0, "rst_rd7");

    applyStimulus(2, WRITE, 30'h9, 32'hCAFE_F00D, "latch_wr9");
    applyStimulus(2, READ, 30'h9, 32'h0, "latch_rd9");

    for (int n = 0; n < 40; n++) begin
      int sel = (n % 2 == 0) ? 2 : 0;
      applyStimulus(sel, logic'($urandom_range(0, 1)), 30'($urandom), $urandom,
                    $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
